// File: rtl/freq_lock_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : freq_lock_sequencer
//  Description : Supervisory lock sequencer for the PSI frequency regulator.
//                Latches a target period, holds the regulator in reset for a
//                short init phase, then grades each PSI window against the
//                target. Declares lock, reports loss of lock, and times out
//                into FAIL.
//  Revision    : 1.0 - initial release
// ============================================================================
module freq_lock_sequencer #(
  parameter int W           = 8,
  parameter int LOCK_COUNT  = 4,
  parameter int LOSS_COUNT  = 2,
  parameter int TIMEOUT_WIN = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic [W-1:0] targetPeriod,
  input  logic [3:0]   tolerance,
  input  logic         psi,
  input  logic [W-1:0] duration,
  output logic [W-1:0] setPeriod,
  output logic         regRst,
  output logic         locked,
  output logic         fail,
  output logic         lostLock,
  output logic [W-1:0] windowCount,
  output logic [2:0]   state
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_INIT   = 3'd1,
    ST_SEEK   = 3'd2,
    ST_LOCKED = 3'd3,
    ST_FAIL   = 3'd4
  } state_t;

  // Thresholds expressed as "count minus one" so they compare against the
  // pre-increment counter value seen on the qualifying event.
  localparam logic [W-1:0] LOCK_LAST    = W'(LOCK_COUNT - 1);
  localparam logic [W-1:0] LOSS_LAST    = W'(LOSS_COUNT - 1);
  localparam logic [W-1:0] TIMEOUT_LAST = W'(TIMEOUT_WIN - 1);
  localparam logic [W-1:0] WC_MAX       = {W{1'b1}};

  state_t         state_q, state_d;
  logic [W-1:0]   set_period_q, set_period_d;
  logic           reg_rst_q, reg_rst_d;
  logic           locked_q, locked_d;
  logic           fail_q, fail_d;
  logic           lost_lock_q, lost_lock_d;
  logic [W-1:0]   window_count_q, window_count_d;
  logic [W-1:0]   match_cnt_q, match_cnt_d;
  logic [W-1:0]   miss_cnt_q, miss_cnt_d;
  logic           init_cnt_q, init_cnt_d;
  logic           psi_d;

  logic           window_evt;
  logic [W:0]     err;
  logic           in_tol;
  logic [W-1:0]   wc_inc;

  // Falling PSI edge marks the end of a measurement window.
  assign window_evt = psi_d & ~psi;

  // Absolute error in W+1 bits so the subtraction never wraps.
  always_comb begin
    if (duration >= set_period_q) begin
      err = {1'b0, duration} - {1'b0, set_period_q};
    end else begin
      err = {1'b0, set_period_q} - {1'b0, duration};
    end
  end

  assign in_tol = (err <= {{(W-3){1'b0}}, tolerance});
  assign wc_inc = (window_count_q == WC_MAX) ? window_count_q : window_count_q + 1'b1;

  // State and output registers; everything the block drives comes from here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      set_period_q   <= '0;
      reg_rst_q      <= 1'b1;
      locked_q       <= 1'b0;
      fail_q         <= 1'b0;
      lost_lock_q    <= 1'b0;
      window_count_q <= '0;
      match_cnt_q    <= '0;
      miss_cnt_q     <= '0;
      init_cnt_q     <= 1'b0;
      psi_d          <= 1'b0;
    end else begin
      state_q        <= state_d;
      set_period_q   <= set_period_d;
      reg_rst_q      <= reg_rst_d;
      locked_q       <= locked_d;
      fail_q         <= fail_d;
      lost_lock_q    <= lost_lock_d;
      window_count_q <= window_count_d;
      match_cnt_q    <= match_cnt_d;
      miss_cnt_q     <= miss_cnt_d;
      init_cnt_q     <= init_cnt_d;
      psi_d          <= psi;
    end
  end

  // Next-state and next-output logic; abort overrides whatever the state chose.
  always_comb begin
    state_d        = state_q;
    set_period_d   = set_period_q;
    reg_rst_d      = reg_rst_q;
    locked_d       = locked_q;
    fail_d         = fail_q;
    lost_lock_d    = 1'b0;
    window_count_d = window_count_q;
    match_cnt_d    = match_cnt_q;
    miss_cnt_d     = miss_cnt_q;
    init_cnt_d     = init_cnt_q;

    case (state_q)
      ST_IDLE: begin
        reg_rst_d = 1'b1;
        if (start) begin
          state_d        = ST_INIT;
          set_period_d   = targetPeriod;
          init_cnt_d     = 1'b0;
          window_count_d = '0;
          match_cnt_d    = '0;
          miss_cnt_d     = '0;
        end
      end

      ST_INIT: begin
        // Two cycles of regulator reset; PSI edges are not graded here.
        reg_rst_d = 1'b1;
        if (init_cnt_q) begin
          state_d   = ST_SEEK;
          reg_rst_d = 1'b0;
        end else begin
          init_cnt_d = 1'b1;
        end
      end

      ST_SEEK: begin
        if (window_evt) begin
          window_count_d = wc_inc;
          if (in_tol && (match_cnt_q == LOCK_LAST)) begin
            // Lock takes precedence over a simultaneous timeout.
            state_d     = ST_LOCKED;
            locked_d    = 1'b1;
            match_cnt_d = '0;
            miss_cnt_d  = '0;
          end else begin
            match_cnt_d = in_tol ? match_cnt_q + 1'b1 : '0;
            if (window_count_q == TIMEOUT_LAST) begin
              state_d   = ST_FAIL;
              fail_d    = 1'b1;
              reg_rst_d = 1'b1;
            end
          end
        end
      end

      ST_LOCKED: begin
        if (window_evt) begin
          if (in_tol) begin
            miss_cnt_d = '0;
          end else if (miss_cnt_q == LOSS_LAST) begin
            // Fall back to SEEK without resetting the regulator.
            state_d        = ST_SEEK;
            locked_d       = 1'b0;
            lost_lock_d    = 1'b1;
            window_count_d = '0;
            match_cnt_d    = '0;
            miss_cnt_d     = '0;
          end else begin
            miss_cnt_d = miss_cnt_q + 1'b1;
          end
        end
      end

      ST_FAIL: begin
        fail_d    = 1'b1;
        reg_rst_d = 1'b1;
        if (start) begin
          state_d        = ST_INIT;
          set_period_d   = targetPeriod;
          fail_d         = 1'b0;
          init_cnt_d     = 1'b0;
          window_count_d = '0;
          match_cnt_d    = '0;
          miss_cnt_d     = '0;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        reg_rst_d = 1'b1;
      end
    endcase

    if (abort) begin
      state_d        = ST_IDLE;
      set_period_d   = set_period_q;
      reg_rst_d      = 1'b1;
      locked_d       = 1'b0;
      fail_d         = 1'b0;
      lost_lock_d    = 1'b0;
      window_count_d = '0;
      match_cnt_d    = '0;
      miss_cnt_d     = '0;
      init_cnt_d     = 1'b0;
    end
  end

  assign setPeriod   = set_period_q;
  assign regRst      = reg_rst_q;
  assign locked      = locked_q;
  assign fail        = fail_q;
  assign lostLock    = lost_lock_q;
  assign windowCount = window_count_q;
  assign state       = state_q;

endmodule
`default_nettype wire

// File: tb/tb_freq_lock_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_freq_lock_sequencer
//  Description : Directed self-checking bench for freq_lock_sequencer with a
//                queue of expected output snapshots.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_freq_lock_sequencer;

  localparam logic [2:0] S_IDLE = 3'd0, S_INIT = 3'd1, S_SEEK = 3'd2,
                         S_LOCK = 3'd3, S_FAIL = 3'd4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] targetPeriod = 8'd0;
  logic [3:0] tolerance = 4'd0;
  logic       psi = 1'b0;
  logic [7:0] duration = 8'd0;
  logic [7:0] setPeriod;
  logic       regRst, locked, fail, lostLock;
  logic [7:0] windowCount;
  logic [2:0] state;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    string      tag;
    logic [2:0] st;
    logic       rr, lk, fl, ll;
    logic [7:0] wc, sp;
  } exp_t;

  exp_t sb[$];

  freq_lock_sequencer #(.W(8), .LOCK_COUNT(4), .LOSS_COUNT(2), .TIMEOUT_WIN(64)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .targetPeriod(targetPeriod), .tolerance(tolerance), .psi(psi),
    .duration(duration), .setPeriod(setPeriod), .regRst(regRst),
    .locked(locked), .fail(fail), .lostLock(lostLock),
    .windowCount(windowCount), .state(state)
  );

  always #5 clk = ~clk;

  // Hard stop so a broken design can never hang the run.
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input string fld, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s.%s observed=%0d expected=%0d", tag, fld, obs, exp);
    end
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL scoreboard observed=empty expected=entry");
    end else begin
      e = sb.pop_front();
      chk(e.tag, "state",       {5'd0, state},    {5'd0, e.st});
      chk(e.tag, "regRst",      {7'd0, regRst},   {7'd0, e.rr});
      chk(e.tag, "locked",      {7'd0, locked},   {7'd0, e.lk});
      chk(e.tag, "fail",        {7'd0, fail},     {7'd0, e.fl});
      chk(e.tag, "lostLock",    {7'd0, lostLock}, {7'd0, e.ll});
      chk(e.tag, "windowCount", windowCount,      e.wc);
      chk(e.tag, "setPeriod",   setPeriod,        e.sp);
    end
  endtask

  // Queue the expected snapshot, advance one edge, then compare.
  task automatic step_exp(input string tag, input logic [2:0] st, input logic rr,
                          input logic lk, input logic fl, input logic ll,
                          input logic [7:0] wc, input logic [7:0] sp);
    exp_t e;
    e.tag = tag; e.st = st; e.rr = rr; e.lk = lk; e.fl = fl; e.ll = ll;
    e.wc = wc; e.sp = sp;
    sb.push_back(e);
    tick();
    check_out();
  endtask

  // Raise PSI for two edges with the given duration, then drop it; the next
  // edge sees the falling edge.
  task automatic fall(input logic [7:0] dur);
    psi = 1'b1;
    duration = dur;
    tick();
    tick();
    psi = 1'b0;
  endtask

  initial begin
    logic [7:0] durs_t0 [8];
    durs_t0 = '{8'd20, 8'd20, 8'd20, 8'd25, 8'd20, 8'd20, 8'd20, 8'd20};

    // Reset state
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.push_back('{"reset", S_IDLE, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0});
    check_out();
    step_exp("idle", S_IDLE, 1, 0, 0, 0, 0, 0);

    // Start, two INIT cycles, then SEEK with the regulator released
    targetPeriod = 8'd20;
    start = 1'b1;
    step_exp("start", S_INIT, 1, 0, 0, 0, 0, 20);
    start = 1'b0;
    targetPeriod = 8'd50;
    step_exp("init2", S_INIT, 1, 0, 0, 0, 0, 20);
    step_exp("seek0", S_SEEK, 0, 0, 0, 0, 0, 20);

    // tolerance 1: 21,19,20,20 locks on the 4th window
    tolerance = 4'd1;
    fall(8'd21); step_exp("w21", S_SEEK, 0, 0, 0, 0, 1, 20);
    fall(8'd19); step_exp("w19", S_SEEK, 0, 0, 0, 0, 2, 20);
    fall(8'd20); step_exp("w20a", S_SEEK, 0, 0, 0, 0, 3, 20);
    fall(8'd20); step_exp("lock1", S_LOCK, 0, 1, 0, 0, 4, 20);

    // A single stray miss is forgiven; two in a row drop lock
    fall(8'd30); step_exp("stray", S_LOCK, 0, 1, 0, 0, 4, 20);
    fall(8'd20); step_exp("recover", S_LOCK, 0, 1, 0, 0, 4, 20);
    fall(8'd30); step_exp("miss1", S_LOCK, 0, 1, 0, 0, 4, 20);
    fall(8'd30); step_exp("lost", S_SEEK, 0, 0, 0, 1, 0, 20);
    step_exp("lost_pulse_end", S_SEEK, 0, 0, 0, 0, 0, 20);

    // tolerance 0: the 25 restarts the match run, lock on window 8
    tolerance = 4'd0;
    for (int i = 0; i < 7; i++) begin
      fall(durs_t0[i]);
      step_exp("tol0", S_SEEK, 0, 0, 0, 0, 8'(i + 1), 20);
    end
    fall(durs_t0[7]);
    step_exp("lock_tol0", S_LOCK, 0, 1, 0, 0, 8, 20);

    // abort + start + falling edge in LOCKED: abort wins, setPeriod held
    psi = 1'b1;
    duration = 8'd30;
    tick();
    tick();
    psi = 1'b0;
    abort = 1'b1;
    start = 1'b1;
    targetPeriod = 8'd99;
    step_exp("abort", S_IDLE, 1, 0, 0, 0, 0, 20);
    abort = 1'b0;
    start = 1'b0;
    step_exp("abort_hold", S_IDLE, 1, 0, 0, 0, 0, 20);

    // Timeout: every window off by 15, FAIL after the 64th edge
    targetPeriod = 8'd20;
    tolerance = 4'd1;
    start = 1'b1;
    step_exp("restart", S_INIT, 1, 0, 0, 0, 0, 20);
    start = 1'b0;
    targetPeriod = 8'd77;
    step_exp("reinit2", S_INIT, 1, 0, 0, 0, 0, 20);
    step_exp("reseek", S_SEEK, 0, 0, 0, 0, 0, 20);
    for (int i = 1; i <= 63; i++) begin
      fall(8'd5);
      step_exp("timeout_run", S_SEEK, 0, 0, 0, 0, 8'(i), 20);
    end
    fall(8'd5);
    step_exp("timeout", S_FAIL, 1, 0, 1, 0, 64, 20);
    step_exp("fail_hold", S_FAIL, 1, 0, 1, 0, 64, 20);

    // Restart from FAIL re-latches the new target
    targetPeriod = 8'd6;
    start = 1'b1;
    step_exp("fail_start", S_INIT, 1, 0, 0, 0, 0, 6);
    start = 1'b0;
    step_exp("fail_init2", S_INIT, 1, 0, 0, 0, 0, 6);
    step_exp("fail_seek", S_SEEK, 0, 0, 0, 0, 0, 6);
    fall(8'd7);
    step_exp("seek_w1", S_SEEK, 0, 0, 0, 0, 1, 6);

    // rst mid-SEEK restores every reset value
    rst = 1'b1;
    step_exp("rst_mid", S_IDLE, 1, 0, 0, 0, 0, 0);
    rst = 1'b0;
    step_exp("rst_after", S_IDLE, 1, 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/freq_lock_sequencer.md
Name: freq_lock_sequencer

Overview:
- Supervisory controller for the PSI frequency regulator.
- Latches a target period, holds the regulator in reset, then releases it and judges each PSI measurement window against the target.
- Declares lock after a run of in-tolerance windows, reports loss of lock, and flags failure on timeout.
- Sits between the configuration/monitor logic and the regulator: it drives the regulator's reset and setPeriod, and consumes the regulator's duration output.

Parameters:
- W, 8, width of period/duration/window counters
- LOCK_COUNT, 4, consecutive in-tolerance windows required to enter LOCKED
- LOSS_COUNT, 2, consecutive out-of-tolerance windows in LOCKED that drop lock
- TIMEOUT_WIN, 64, windows allowed in SEEK before FAIL (1..2^W-1)

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  begin acquisition; honoured in IDLE and FAIL only
- abort  input  1  return to IDLE from any state
- targetPeriod  input  W  desired PSI high duration; sampled only on an accepted start
- tolerance  input  4  allowed absolute error, in clk cycles
- psi  input  1  same PSI signal that feeds the regulator
- duration  input  W  regulator duration output
- setPeriod  output  W  latched target, driven to the regulator
- regRst  output  1  regulator reset
- locked  output  1  high while in LOCKED
- fail  output  1  high while in FAIL
- lostLock  output  1  one-cycle pulse on LOCKED->SEEK
- windowCount  output  W  windows evaluated since entering SEEK; saturates at 2^W-1
- state  output  3  IDLE=0, INIT=1, SEEK=2, LOCKED=3, FAIL=4

Behaviour:
- All outputs are registered.
- Reset values:
  - state=IDLE, regRst=1, setPeriod=0, locked=0, fail=0, lostLock=0, windowCount=0.
  - Internal psi_d=0, matchCnt=0, missCnt=0, initCnt=0.
- Priority each cycle: rst > abort > start > window evaluation.
- abort (not rst): next state IDLE; regRst=1; locked, fail and lostLock cleared; counters cleared; setPeriod held.
- IDLE:
  - regRst=1.
  - start -> INIT. setPeriod<=targetPeriod in the same edge.
- INIT:
  - regRst=1 for exactly 2 cycles (initCnt), then -> SEEK with regRst=0.
  - PSI edges are ignored.
  - windowCount, matchCnt and missCnt are cleared on entry.
- Window event: psi_d==1 && psi==0, where psi_d is psi registered every cycle.
  - duration is sampled in the same cycle as the edge.
  - err = |duration - setPeriod|, computed in W+1 bits with no wrap.
  - inTol = (err <= tolerance).
- SEEK:
  - On each window event, windowCount increments.
  - inTol increments matchCnt; otherwise matchCnt clears.
  - If matchCnt+1 == LOCK_COUNT on an inTol event: -> LOCKED and locked=1 on the next cycle.
  - Else if windowCount+1 == TIMEOUT_WIN: -> FAIL and fail=1.
  - Lock wins when both conditions hold on the same event.
- LOCKED:
  - An out-of-tolerance event increments missCnt; an inTol event clears it.
  - If missCnt+1 == LOSS_COUNT: -> SEEK with lostLock=1 for one cycle, locked=0, and windowCount, matchCnt and missCnt cleared.
  - The regulator is not reset on loss of lock.
- FAIL:
  - fail=1 and regRst=1, held until start or abort.
  - start -> INIT and re-latches targetPeriod.
  - abort -> IDLE.
- start is ignored in INIT, SEEK and LOCKED. targetPeriod changes have no effect until the next accepted start.
- start and abort in the same cycle: abort wins.
- Window event coinciding with abort: event discarded.
- windowCount saturates and never wraps. TIMEOUT_WIN < 2^W guarantees the timeout fires before saturation.
- tolerance=0 requires an exact match. setPeriod=0 is legal.
- rst asserted mid-operation: all reset values apply on the next edge, regardless of state.

Test Plan:
- Reset then start with targetPeriod=20 -> setPeriod=20 the next cycle; regRst=1 for 2 INIT cycles, then 0; state=SEEK.
- SEEK, tolerance=1, four consecutive windows with duration 21,19,20,20 -> locked=1 and state=LOCKED one cycle after the 4th falling edge; windowCount=4.
- SEEK, tolerance=0, durations 20,20,20,25,20,20,20,20 -> lock only after the 8th window (matchCnt reset by 25).
- LOCKED, two consecutive windows with duration 30 (target 20, tol 1) -> lostLock=1 pulse for 1 cycle, state=SEEK, windowCount=0. A single stray window of 30 followed by 20 -> remains LOCKED.
- TIMEOUT_WIN=64, every window duration=5 vs target 20 -> fail=1 and state=FAIL after the 64th edge; start with targetPeriod=6 -> INIT, setPeriod=6.
- abort asserted in LOCKED together with start and a psi falling edge -> state=IDLE, regRst=1, locked=0, counters 0, setPeriod unchanged. rst mid-SEEK -> all reset values.
